// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_ctrl_pkg
// Purpose  : Shared types and constants for the FIR burst sequencer. Holds
//            the controller state encoding, the default datapath sizes and a
//            constant-evaluable ceil(log2) helper.
// Revision : 1.0 - initial release
// ============================================================================
package fir_ctrl_pkg;

  // Sequencer states: ACCEPT takes input samples, FLUSH feeds zeros to the
  // FIR after a burst. FLUSH is only reachable in the tail-flush build.
  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    FLUSH  = 1'b1
  } ctrl_state_e;

  localparam int DEF_TAPS = 16;
  localparam int DEF_DW   = 12;
  localparam int DEF_OW   = 29;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fir_ctrl_fifo
// Purpose  : Synchronous first-word-fall-through FIFO on registered storage.
//            The head entry is presented on dout_o whenever empty_o is low.
//            Pushes while full and pops while empty are ignored.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            push_i, din_i  - write strobe and data
//            pop_i          - consume the head entry
//            dout_o         - head entry (valid when !empty_o)
//            count_o        - number of stored entries (0..DEPTH)
//            full_o/empty_o - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module fir_ctrl_fifo
  import fir_ctrl_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic [clog2(DEPTH):0] count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int c_aw = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q;
  logic [c_aw-1:0]  rd_ptr_q;
  logic [c_aw:0]    count_q;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (count_q == (c_aw+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only observed after it was written.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_stream_ctrl
// Purpose  : Burst sequencer in front of a symmetric FIR without backpressure.
//            Admits valid/ready samples only when every issued item is sure
//            to find a slot in the output FIFO, drives the FIR en/xin pair,
//            and collects results with end-of-burst marking.
// Option   : FIR_CTRL_TAIL_FLUSH_EN - when defined, every burst is followed
//            by TAPS-1 zero samples and m_last marks the final tail output.
// Ports    : s_valid/s_ready/s_data/s_last  - input sample stream
//            fir_en/fir_xin                 - FIR input (registered)
//            fir_valid/fir_yout             - FIR result
//            m_valid/m_ready/m_data/m_last  - output result stream
//            err                            - sticky protocol error
// Revision : 1.0 - initial release
// ============================================================================
module fir_stream_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS       = DEF_TAPS,
  parameter int DW         = DEF_DW,
  parameter int OW         = DEF_OW,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          fir_en,
  output logic [DW-1:0] fir_xin,
  input  logic          fir_valid,
  input  logic [OW-1:0] fir_yout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_data,
  output logic          m_last,
  output logic          err
);

  localparam int c_cw = clog2(FIFO_DEPTH);

  logic          fir_en_q, fir_en_d;
  logic [DW-1:0] fir_xin_q, fir_xin_d;
  logic [c_cw:0] inflight_q, inflight_d;
  logic          err_q, err_d;

  logic          w_tag_in;
  logic          w_tag_head;
  logic          w_tag;
  logic          w_tag_full;
  logic          w_tag_empty;
  logic [c_cw:0] w_tag_cnt;

  logic [OW:0]   w_out_head;
  logic [c_cw:0] w_out_cnt;
  logic          w_out_full;
  logic          w_out_empty;

  logic [c_cw+1:0] w_occ;
  logic            w_credit;
  logic            w_ret_ok;
  logic            w_pop;

`ifdef FIR_CTRL_TAIL_FLUSH_EN
  localparam int c_zw = clog2(TAPS) + 1;
  ctrl_state_e     state_q, state_d;
  logic [c_zw-1:0] zcnt_q, zcnt_d;
`endif

  // Everything that will eventually occupy an output slot: results still in
  // the FIR, results already queued, and the item being handed over now.
  assign w_occ    = (c_cw+2)'(inflight_q) + (c_cw+2)'(w_out_cnt) + (c_cw+2)'(fir_en_q);
  assign w_credit = (w_occ < (c_cw+2)'(FIFO_DEPTH)) && !w_tag_full;

  // A result is only accepted when something is actually outstanding.
  assign w_ret_ok = fir_valid && (inflight_q != '0) && (w_tag_cnt != '0);
  assign w_tag    = w_tag_head && !w_tag_empty;

  // ---------------------------------------------------------------------------
  // Issue side: admission, FIR drive and (optionally) the zero tail
  // ---------------------------------------------------------------------------
  always_comb begin
    s_ready   = 1'b0;
    fir_en_d  = 1'b0;
    fir_xin_d = fir_xin_q;
    w_tag_in  = 1'b0;
`ifdef FIR_CTRL_TAIL_FLUSH_EN
    state_d   = state_q;
    zcnt_d    = zcnt_q;
    case (state_q)
      ACCEPT: begin
        s_ready = w_credit;
        if (s_valid && w_credit) begin
          fir_en_d  = 1'b1;
          fir_xin_d = s_data;
          if (s_last) begin
            state_d = FLUSH;
            zcnt_d  = c_zw'(TAPS - 1);
          end
        end
      end
      FLUSH: begin
        if (w_credit) begin
          fir_en_d  = 1'b1;
          fir_xin_d = '0;
          zcnt_d    = zcnt_q - 1'b1;
          // The last zero carries the end-of-burst tag.
          if (zcnt_q == c_zw'(1)) begin
            w_tag_in = 1'b1;
            state_d  = ACCEPT;
          end
        end
      end
      default: state_d = ACCEPT;
    endcase
`else
    s_ready = w_credit;
    if (s_valid && w_credit) begin
      fir_en_d  = 1'b1;
      fir_xin_d = s_data;
      w_tag_in  = s_last;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Return side bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight_d = inflight_q;
    if (fir_en_q && !w_ret_ok) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!fir_en_q && w_ret_ok) begin
      inflight_d = inflight_q - 1'b1;
    end
    err_d = err_q
          | (fir_valid && (inflight_q == '0))
          | (w_ret_ok && w_out_full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fir_en_q   <= 1'b0;
      fir_xin_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      fir_en_q   <= fir_en_d;
      fir_xin_q  <= fir_xin_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

`ifdef FIR_CTRL_TAIL_FLUSH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCEPT;
      zcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      zcnt_q  <= zcnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Tag FIFO: one end-of-burst bit per issued item, popped as results return
  // ---------------------------------------------------------------------------
  fir_ctrl_fifo #(
    .WIDTH (1),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fir_en_d),
    .din_i   (w_tag_in),
    .pop_i   (w_ret_ok),
    .dout_o  (w_tag_head),
    .count_o (w_tag_cnt),
    .full_o  (w_tag_full),
    .empty_o (w_tag_empty)
  );

  // ---------------------------------------------------------------------------
  // Output FIFO: {last, result}
  // ---------------------------------------------------------------------------
  assign w_pop = !w_out_empty && m_ready;

  fir_ctrl_fifo #(
    .WIDTH (OW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_ret_ok),
    .din_i   ({w_tag, fir_yout}),
    .pop_i   (w_pop),
    .dout_o  (w_out_head),
    .count_o (w_out_cnt),
    .full_o  (w_out_full),
    .empty_o (w_out_empty)
  );

  assign fir_en  = fir_en_q;
  assign fir_xin = fir_xin_q;
  assign m_valid = !w_out_empty;
  // Storage is not reset, so the head is masked while nothing is queued.
  assign m_data  = w_out_empty ? '0 : w_out_head[OW-1:0];
  assign m_last  = !w_out_empty && w_out_head[OW];
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_stream_ctrl
// Purpose  : Directed self-checking bench for fir_stream_ctrl with a
//            behavioural 16-tap FIR of fixed latency attached. Adapts its
//            expectations to FIR_CTRL_TAIL_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_stream_ctrl;

  localparam int DW   = 12;
  localparam int OW   = 29;
  localparam int TAPS = 16;
  localparam int FD   = 8;
  localparam int LAT  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          m_ready = 1'b1;
  logic          inj = 1'b0;
  logic          s_ready, fir_en, fir_valid, m_valid, m_last, err;
  logic [DW-1:0] fir_xin;
  logic [OW-1:0] fir_yout, m_data;

  int npass = 0;
  int ntot  = 0;

  int coef [TAPS] = '{11, 31, 63, 104, 152, 198, 235, 255,
                      255, 235, 198, 152, 104, 63, 31, 11};

  always #10 clk = ~clk;

  fir_stream_ctrl #(
    .TAPS(TAPS), .DW(DW), .OW(OW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .fir_en(fir_en), .fir_xin(fir_xin),
    .fir_valid(fir_valid), .fir_yout(fir_yout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err(err)
  );

  // Behavioural FIR: direct-form, LAT cycles from en to valid, reset with rst.
  logic [DW-1:0] hist [TAPS-1];
  logic [OW-1:0] acc;
  logic [LAT-1:0] pv;
  logic [OW-1:0] py [LAT];

  always_comb begin
    acc = OW'(coef[0]) * OW'(fir_xin);
    for (int i = 1; i < TAPS; i++) acc = acc + OW'(coef[i]) * OW'(hist[i-1]);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS-1; i++) hist[i] <= '0;
      for (int i = 0; i < LAT; i++) py[i] <= '0;
      pv <= '0;
    end else begin
      if (fir_en) begin
        hist[0] <= fir_xin;
        for (int i = 1; i < TAPS-1; i++) hist[i] <= hist[i-1];
      end
      pv    <= {pv[LAT-2:0], fir_en};
      py[0] <= acc;
      for (int i = 1; i < LAT; i++) py[i] <= py[i-1];
    end
  end

  assign fir_valid = pv[LAT-1] | inj;
  assign fir_yout  = inj ? OW'(123) : py[LAT-1];

  // Output / issue monitor
  logic [OW-1:0] got_d [$];
  logic          got_l [$];
  int            en_cnt, zero_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      got_d.delete();
      got_l.delete();
      en_cnt   <= 0;
      zero_cnt <= 0;
    end else begin
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
      end
      if (fir_en) en_cnt <= en_cnt + 1;
      if (fir_en && fir_xin == '0) zero_cnt <= zero_cnt + 1;
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1; inj = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int t = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      ntot++;
      $display("FAIL send_timeout: s_ready=%b, required 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (got_d.size() < n && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (40) @(negedge clk);
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return (i == 0) ? DW'(1) : (i == 16) ? DW'(2) : DW'(0);
  endfunction

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    do_reset();
    ntot++;
    if ({s_ready, fir_en, m_valid, m_last, err} !== 5'b10000)
      $display("FAIL reset_flags: {s_ready,fir_en,m_valid,m_last,err}=%b, required 10000",
               {s_ready, fir_en, m_valid, m_last, err});
    else npass++;
    ntot++;
    if (fir_xin !== '0) $display("FAIL reset_fir_xin: got %0d, required 0", fir_xin);
    else npass++;
    ntot++;
    if (m_data !== '0) $display("FAIL reset_m_data: got %0d, required 0", m_data);
    else npass++;
  endtask

  task automatic test_impulse(input bit rst_first);
    logic [TAPS-1:0] lv;
    if (rst_first) do_reset();
    m_ready = 1'b1;
`ifdef FIR_CTRL_TAIL_FLUSH_EN
    send(DW'(1), 1'b1);
`else
    send(DW'(1), 1'b0);
`endif
    ntot++;
    if ({fir_en, fir_xin} !== {1'b1, DW'(1)})
      $display("FAIL impulse_issue: fir_en=%b fir_xin=%0d, required 1 and 1", fir_en, fir_xin);
    else npass++;
`ifndef FIR_CTRL_TAIL_FLUSH_EN
    for (int i = 1; i < TAPS; i++) send(DW'(0), (i == TAPS-1));
`endif
    wait_out(TAPS);
    ntot++;
    if (got_d.size() !== TAPS)
      $display("FAIL impulse_count: got %0d outputs, required %0d", got_d.size(), TAPS);
    else npass++;
    lv = 'x;
    for (int i = 0; i < TAPS; i++) begin
      logic [OW-1:0] d;
      d = (i < got_d.size()) ? got_d[i] : 'x;
      if (i < got_l.size()) lv[i] = got_l[i];
      ntot++;
      if (d !== OW'(coef[i])) $display("FAIL impulse_data[%0d]: got %0d, required %0d", i, d, coef[i]);
      else npass++;
    end
    ntot++;
    if (lv !== 16'h8000) $display("FAIL impulse_last: got %b, required %b", lv, 16'h8000);
    else npass++;
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int t = 0;
    logic rdy;
    do_reset();
    m_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      s_valid = 1'b1; s_data = pat(idx); rdy = s_ready;
      @(negedge clk);
      if (rdy) idx++;
    end
    ntot++;
    if (idx !== 8) $display("FAIL bp_issues: got %0d, required 8", idx);
    else npass++;
    ntot++;
    if (s_ready !== 1'b0) $display("FAIL bp_s_ready: got %b, required 0", s_ready);
    else npass++;
    ntot++;
    if (en_cnt !== 8) $display("FAIL bp_fir_en_count: got %0d, required 8", en_cnt);
    else npass++;
    ntot++;
    if ({m_valid, m_last, m_data} !== {1'b1, 1'b0, OW'(11)})
      $display("FAIL bp_head_hold: m_valid=%b m_last=%b m_data=%0d, required 1 0 11",
               m_valid, m_last, m_data);
    else npass++;
    ntot++;
    if (got_d.size() !== 0) $display("FAIL bp_no_drain: got %0d outputs, required 0", got_d.size());
    else npass++;
    m_ready = 1'b1;
    while (idx < 20 && t < 300) begin
      s_valid = 1'b1; s_data = pat(idx); rdy = s_ready;
      @(negedge clk);
      if (rdy) idx++;
      t++;
    end
    s_valid = 1'b0;
    wait_out(20);
    ntot++;
    if (got_d.size() !== 20) $display("FAIL bp_count: got %0d outputs, required 20", got_d.size());
    else npass++;
    for (int n = 0; n < 20; n++) begin
      logic [OW-1:0] d;
      int e;
      e = (n < 16) ? coef[n] : 2 * coef[n-16];
      d = (n < got_d.size()) ? got_d[n] : 'x;
      ntot++;
      if (d !== OW'(e) || (n < got_l.size() && got_l[n] !== 1'b0))
        $display("FAIL bp_data[%0d]: got %0d, required %0d with m_last 0", n, d, e);
      else npass++;
    end
  endtask

  task automatic test_burst();
`ifdef FIR_CTRL_TAIL_FLUSH_EN
    localparam int NB = 3 + TAPS - 1;
`else
    localparam int NB = 3;
`endif
    logic [NB-1:0] lv;
    logic [NB-1:0] lexp;
    do_reset();
    send(DW'(1), 1'b0);
    send(DW'(1), 1'b0);
    send(DW'(1), 1'b1);
    wait_out(NB);
    ntot++;
    if (got_d.size() !== NB) $display("FAIL burst_count: got %0d, required %0d", got_d.size(), NB);
    else npass++;
    lv = 'x;
    lexp = '0;
    lexp[NB-1] = 1'b1;
    for (int n = 0; n < NB; n++) begin
      int e = 0;
      logic [OW-1:0] d;
      for (int k = 0; k < 3; k++) if (n - k >= 0 && n - k < TAPS) e += coef[n-k];
      d = (n < got_d.size()) ? got_d[n] : 'x;
      if (n < got_l.size()) lv[n] = got_l[n];
      ntot++;
      if (d !== OW'(e)) $display("FAIL burst_data[%0d]: got %0d, required %0d", n, d, e);
      else npass++;
    end
    ntot++;
    if (lv !== lexp) $display("FAIL burst_last: got %b, required %b", lv, lexp);
    else npass++;
    ntot++;
    if (zero_cnt !== NB - 3) $display("FAIL burst_zero_issues: got %0d, required %0d", zero_cnt, NB - 3);
    else npass++;
    ntot++;
    if (en_cnt !== NB) $display("FAIL burst_issues: got %0d, required %0d", en_cnt, NB);
    else npass++;
  endtask

`ifdef FIR_CTRL_TAIL_FLUSH_EN
  task automatic test_back_to_back();
    localparam int NA = 4 + TAPS - 1;
    int nl = 0;
    int nz = 0;
    do_reset();
    for (int i = 0; i < 4; i++) send(DW'(100), (i == 3));
    for (int i = 0; i < 4; i++) send(DW'(0), (i == 3));
    wait_out(2 * NA);
    ntot++;
    if (got_d.size() !== 2 * NA) $display("FAIL b2b_count: got %0d, required %0d", got_d.size(), 2 * NA);
    else npass++;
    ntot++;
    if (got_d.size() == 0 || got_d[0] !== OW'(1100))
      $display("FAIL b2b_first: got %0d, required 1100", (got_d.size() > 0) ? got_d[0] : 'x);
    else npass++;
    for (int n = NA; n < got_d.size(); n++) if (got_d[n] !== '0) nz++;
    ntot++;
    if (nz !== 0) $display("FAIL b2b_b_zero: %0d nonzero B outputs, required 0", nz);
    else npass++;
    foreach (got_l[n]) if (got_l[n] === 1'b1) nl++;
    ntot++;
    if (nl !== 2 || got_l.size() != 2 * NA || got_l[NA-1] !== 1'b1 || got_l[2*NA-1] !== 1'b1)
      $display("FAIL b2b_last: %0d m_last pulses, required 2 at outputs %0d and %0d", nl, NA - 1, 2 * NA - 1);
    else npass++;
  endtask
`endif

  task automatic test_error();
    do_reset();
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    ntot++;
    if (err !== 1'b1) $display("FAIL err_set: got %b, required 1", err);
    else npass++;
    ntot++;
    if (m_valid !== 1'b0) $display("FAIL err_no_push: m_valid=%b, required 0", m_valid);
    else npass++;
    repeat (5) @(negedge clk);
    ntot++;
    if ({err, m_valid} !== 2'b10) $display("FAIL err_sticky: err=%b m_valid=%b, required 1 0", err, m_valid);
    else npass++;
  endtask

  task automatic test_reset_mid();
    int t = 0;
    do_reset();
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
`ifdef FIR_CTRL_TAIL_FLUSH_EN
    send(DW'(5), 1'b1);
    while (zero_cnt < 7 && t < 200) begin
      @(negedge clk);
      t++;
    end
    ntot++;
    if (zero_cnt !== 7) $display("FAIL mid_flush_reach: zero issues %0d, required 7", zero_cnt);
    else npass++;
`else
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(DW'(3), 1'b0);
    repeat (6) @(negedge clk);
    ntot++;
    if ({m_valid, err} !== 2'b11) $display("FAIL mid_busy: m_valid=%b err=%b, required 1 1", m_valid, err);
    else npass++;
`endif
    rst = 1'b1;
    #1;
    ntot++;
    if ({s_ready, fir_en, m_valid, m_last, err} !== 5'b10000)
      $display("FAIL mid_reset_flags: {s_ready,fir_en,m_valid,m_last,err}=%b, required 10000",
               {s_ready, fir_en, m_valid, m_last, err});
    else npass++;
    ntot++;
    if ({fir_xin, m_data} !== '0)
      $display("FAIL mid_reset_data: fir_xin=%0d m_data=%0d, required 0 0", fir_xin, m_data);
    else npass++;
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    test_impulse(1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse(1'b1);
    test_backpressure();
    test_burst();
`ifdef FIR_CTRL_TAIL_FLUSH_EN
    test_back_to_back();
`endif
    test_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
